// File: rtl/morse_tx_if.sv
// rtl/morse_tx_if.sv - character handshake between a text source and the Morse keyer
interface morse_tx_if;
    logic       char_valid;
    logic [5:0] char_code;
    logic       char_ready;

    modport master (
        output char_valid,
        output char_code,
        input  char_ready
    );

    modport slave (
        input  char_valid,
        input  char_code,
        output char_ready
    );
endinterface

// File: rtl/morse_tx.sv
// rtl/morse_tx.sv - ITU Morse keyer driving one on/off line from 6-bit character codes
// Define MORSE_TX_DIGITS_EN to key codes 26-35 as digits 0-9; otherwise they are rejected as invalid.
module morse_tx #(
    parameter int UNIT_CYCLES = 50
) (
    input  logic      clk,
    input  logic      rst_n,
    morse_tx_if.slave cin,
    output logic      morse_out,
    output logic      busy,
    output logic      err_pulse
);
    localparam int CW          = $clog2(UNIT_CYCLES);
    localparam int CODE_WSPACE = 36;

    typedef enum logic [2:0] {IDLE, MARK, SPACE, LGAP, WGAP} state_t;

    state_t        state_q, state_d, start_state;
    logic [CW-1:0] cyc_q;
    logic [1:0]    unit_q;
    logic [2:0]    sym_q, len_q;
    logic [4:0]    pat_q;
    logic          morse_q, err_q, rdy_en_q;

    logic          rom_ok;
    logic [2:0]    rom_len;
    logic [4:0]    rom_pat;
    logic          unit_stb, gap_done, accept;
    logic          enter, load, advance, err_d, rdy_en_d;
    logic [1:0]    mark_last;

    // {valid, length, pattern}; pattern is left-aligned so the current symbol is always bit 4
    function automatic logic [8:0] rom(input logic [5:0] c);
        case (c)
            6'd0:  rom = {1'b1, 3'd2, 5'b01000};
            6'd1:  rom = {1'b1, 3'd4, 5'b10000};
            6'd2:  rom = {1'b1, 3'd4, 5'b10100};
            6'd3:  rom = {1'b1, 3'd3, 5'b10000};
            6'd4:  rom = {1'b1, 3'd1, 5'b00000};
            6'd5:  rom = {1'b1, 3'd4, 5'b00100};
            6'd6:  rom = {1'b1, 3'd3, 5'b11000};
            6'd7:  rom = {1'b1, 3'd4, 5'b00000};
            6'd8:  rom = {1'b1, 3'd2, 5'b00000};
            6'd9:  rom = {1'b1, 3'd4, 5'b01110};
            6'd10: rom = {1'b1, 3'd3, 5'b10100};
            6'd11: rom = {1'b1, 3'd4, 5'b01000};
            6'd12: rom = {1'b1, 3'd2, 5'b11000};
            6'd13: rom = {1'b1, 3'd2, 5'b10000};
            6'd14: rom = {1'b1, 3'd3, 5'b11100};
            6'd15: rom = {1'b1, 3'd4, 5'b01100};
            6'd16: rom = {1'b1, 3'd4, 5'b11010};
            6'd17: rom = {1'b1, 3'd3, 5'b01000};
            6'd18: rom = {1'b1, 3'd3, 5'b00000};
            6'd19: rom = {1'b1, 3'd1, 5'b10000};
            6'd20: rom = {1'b1, 3'd3, 5'b00100};
            6'd21: rom = {1'b1, 3'd4, 5'b00010};
            6'd22: rom = {1'b1, 3'd3, 5'b01100};
            6'd23: rom = {1'b1, 3'd4, 5'b10010};
            6'd24: rom = {1'b1, 3'd4, 5'b10110};
            6'd25: rom = {1'b1, 3'd4, 5'b11000};
`ifdef MORSE_TX_DIGITS_EN
            6'd26: rom = {1'b1, 3'd5, 5'b11111};
            6'd27: rom = {1'b1, 3'd5, 5'b01111};
            6'd28: rom = {1'b1, 3'd5, 5'b00111};
            6'd29: rom = {1'b1, 3'd5, 5'b00011};
            6'd30: rom = {1'b1, 3'd5, 5'b00001};
            6'd31: rom = {1'b1, 3'd5, 5'b00000};
            6'd32: rom = {1'b1, 3'd5, 5'b10000};
            6'd33: rom = {1'b1, 3'd5, 5'b11000};
            6'd34: rom = {1'b1, 3'd5, 5'b11100};
            6'd35: rom = {1'b1, 3'd5, 5'b11110};
`endif
            default: rom = 9'd0;
        endcase
    endfunction

    always_comb {rom_ok, rom_len, rom_pat} = rom(cin.char_code);

    assign unit_stb  = (cyc_q == CW'(UNIT_CYCLES - 1));
    assign mark_last = pat_q[4] ? 2'd2 : 2'd0;
    assign gap_done  = unit_stb && ((state_q == LGAP && unit_q == 2'd2) ||
                                    (state_q == WGAP && unit_q == 2'd3));
    // Ready looks ahead into the last gap cycle so characters chain with no idle cycle
    assign cin.char_ready = rdy_en_q && (state_q == IDLE || gap_done);
    assign accept         = cin.char_valid && cin.char_ready;

    always_comb begin
        start_state = IDLE;
        if (rom_ok)
            start_state = MARK;
        else if (cin.char_code == 6'(CODE_WSPACE))
            start_state = WGAP;
    end

    always_comb begin
        state_d  = state_q;
        enter    = 1'b0;
        load     = 1'b0;
        advance  = 1'b0;
        err_d    = 1'b0;
        rdy_en_d = 1'b1;
        if (accept) begin
            state_d  = start_state;
            enter    = 1'b1;
            load     = rom_ok;
            err_d    = (start_state == IDLE);
            rdy_en_d = (start_state != IDLE);
        end else begin
            case (state_q)
                MARK: begin
                    if (unit_stb && unit_q == mark_last) begin
                        state_d = (sym_q == len_q - 3'd1) ? LGAP : SPACE;
                        enter   = 1'b1;
                    end
                end
                SPACE: begin
                    if (unit_stb) begin
                        state_d = MARK;
                        enter   = 1'b1;
                        advance = 1'b1;
                    end
                end
                LGAP, WGAP: begin
                    if (gap_done) begin
                        state_d = IDLE;
                        enter   = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cyc_q    <= '0;
            unit_q   <= '0;
            sym_q    <= '0;
            len_q    <= '0;
            pat_q    <= '0;
            morse_q  <= 1'b0;
            err_q    <= 1'b0;
            rdy_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            morse_q  <= (state_d == MARK);
            err_q    <= err_d;
            rdy_en_q <= rdy_en_d;
            if (enter) begin
                cyc_q  <= '0;
                unit_q <= '0;
            end else if (state_q != IDLE) begin
                cyc_q <= unit_stb ? '0 : cyc_q + CW'(1);
                if (unit_stb)
                    unit_q <= unit_q + 2'd1;
            end
            if (accept)
                sym_q <= '0;
            else if (advance)
                sym_q <= sym_q + 3'd1;
            if (load) begin
                len_q <= rom_len;
                pat_q <= rom_pat;
            end else if (advance) begin
                pat_q <= {pat_q[3:0], 1'b0};
            end
        end
    end

    assign morse_out = morse_q;
    assign busy      = (state_q != IDLE);
    assign err_pulse = err_q;
endmodule
